// File: rtl/mem_line_sequencer_if.sv
// Request/response bundle for mem_line_sequencer.
// slave = sequencer view; master = requester plus word-bus view.
interface mem_line_sequencer_if;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_we;
  logic [255:0] mem_req_data;
  logic         mem_resp_valid;
  logic [255:0] mem_resp_data;
  logic         bus_req_valid;
  logic         bus_req_ready;
  logic [31:0]  bus_req_addr;
  logic         bus_req_we;
  logic [31:0]  bus_req_wdata;
  logic         bus_resp_valid;
  logic [31:0]  bus_resp_rdata;
  logic         busy;
  logic         timeout_err;

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_data,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata,
    output mem_resp_valid, mem_resp_data,
    output bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata,
    output busy, timeout_err
  );

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_data,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata,
    input  mem_resp_valid, mem_resp_data,
    input  bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata,
    input  busy, timeout_err
  );
endinterface

// File: rtl/mem_line_sequencer.sv
// Splits a 256-bit cache line into eight 32-bit word-bus beats, one outstanding at a time.
// Optional build macro MEM_SEQ_TIMEOUT_EN adds a per-beat response timeout with sticky timeout_err.
module mem_line_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  mem_line_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t       state_q;
  logic [2:0]   k_q;
  logic [26:0]  addr_q;
  logic         we_q;
  logic [255:0] line_q;
  logic         mem_resp_valid_q;
  logic [255:0] mem_resp_data_q;
  logic         bus_req_valid_q;
  logic [31:0]  bus_req_addr_q;
  logic         bus_req_we_q;
  logic [31:0]  bus_req_wdata_q;
  logic         busy_q;

  logic [2:0]   k_d;
  logic [255:0] line_d;
  logic         unused_addr_lsb;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign unused_addr_lsb = ^bus.mem_req_addr[4:0];
  assign k_d = k_q + 3'd1;

  // Line buffer with the current beat's read word merged in.
  always_comb begin
    line_d = line_q;
    line_d[{k_q, 5'b0} +: 32] = bus.bus_resp_rdata;
  end

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             timeout_err_q;
  logic             tmo_hit;

  assign tmo_hit         = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      k_q              <= '0;
      addr_q           <= '0;
      we_q             <= 1'b0;
      line_q           <= '0;
      mem_resp_valid_q <= 1'b0;
      mem_resp_data_q  <= '0;
      bus_req_valid_q  <= 1'b0;
      bus_req_addr_q   <= '0;
      bus_req_we_q     <= 1'b0;
      bus_req_wdata_q  <= '0;
      busy_q           <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
      tmo_cnt_q        <= '0;
      timeout_err_q    <= 1'b0;
`endif
    end else begin
      mem_resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (bus.mem_req_valid) begin
          // Reads start from a zeroed buffer so unreceived words read as 0.
          addr_q          <= bus.mem_req_addr[31:5];
          we_q            <= bus.mem_req_we;
          line_q          <= bus.mem_req_we ? bus.mem_req_data : '0;
          k_q             <= '0;
          bus_req_valid_q <= 1'b1;
          bus_req_addr_q  <= {bus.mem_req_addr[31:5], 3'd0, 2'b00};
          bus_req_we_q    <= bus.mem_req_we;
          bus_req_wdata_q <= bus.mem_req_we ? bus.mem_req_data[31:0] : 32'd0;
          busy_q          <= 1'b1;
          state_q         <= REQ;
        end
        REQ: if (bus.bus_req_ready) begin
          bus_req_valid_q <= 1'b0;
          state_q         <= RESP;
`ifdef MEM_SEQ_TIMEOUT_EN
          tmo_cnt_q       <= '0;
`endif
        end
        RESP: begin
          if (bus.bus_resp_valid) begin
            if (!we_q) line_q <= line_d;
            if (k_q == 3'd7) begin
              state_q          <= DONE;
              mem_resp_valid_q <= 1'b1;
              if (!we_q) mem_resp_data_q <= line_d;
            end else begin
              k_q             <= k_d;
              bus_req_valid_q <= 1'b1;
              bus_req_addr_q  <= {addr_q, k_d, 2'b00};
              bus_req_wdata_q <= line_q[{k_d, 5'b0} +: 32];
              state_q         <= REQ;
            end
          end
`ifdef MEM_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            timeout_err_q    <= 1'b1;
            state_q          <= DONE;
            mem_resp_valid_q <= 1'b1;
            if (!we_q) mem_resp_data_q <= line_q;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          k_q     <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_resp_valid = mem_resp_valid_q;
  assign bus.mem_resp_data  = mem_resp_data_q;
  assign bus.bus_req_valid  = bus_req_valid_q;
  assign bus.bus_req_addr   = bus_req_addr_q;
  assign bus.bus_req_we     = bus_req_we_q;
  assign bus.bus_req_wdata  = bus_req_wdata_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_mem_line_sequencer.sv
// Directed bench for mem_line_sequencer with a reactive word-bus slave model.
module tb_mem_line_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;

  mem_line_sequencer_if sif();

  mem_line_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Word-bus slave configuration, set by the directed sequence
  int          stall_cfg = 0;
  int          drop_beat = -1;
  logic        spur      = 1'b0;
  logic [31:0] rd_base   = 32'h100;

  // Slave model state and observations
  int          stall_cnt  = 0;
  int          nbeats     = 0;
  logic [31:0] b_addr  [128];
  logic        b_we    [128];
  logic [31:0] b_wdata [128];
  logic        resp_pending = 1'b0;
  int          pend_k     = 0;
  int          unstable   = 0;
  int          stall_seen = 0;
  int          drops      = 0;
  int          pulses     = 0;
  logic        prev_wait  = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] prev_wdata = '0;
  logic        prev_we    = 1'b0;

  always @(posedge clock) begin
    if (!reset) begin
      resp_pending = 1'b0;
      prev_wait    = 1'b0;
    end else begin
      if (sif.mem_resp_valid) pulses++;
      if (prev_wait) begin
        if (!sif.bus_req_valid) drops++;
        else if (sif.bus_req_addr !== prev_addr || sif.bus_req_wdata !== prev_wdata ||
                 sif.bus_req_we !== prev_we) unstable++;
      end
      if (sif.bus_resp_valid && resp_pending) resp_pending = 1'b0;
      if (sif.bus_req_valid && sif.bus_req_ready) begin
        if (nbeats < 128) begin
          b_addr[nbeats]  = sif.bus_req_addr;
          b_we[nbeats]    = sif.bus_req_we;
          b_wdata[nbeats] = sif.bus_req_wdata;
        end
        nbeats++;
        resp_pending = 1'b1;
        pend_k       = int'(sif.bus_req_addr[4:2]);
      end
      prev_wait  = sif.bus_req_valid && !sif.bus_req_ready;
      if (prev_wait) stall_seen++;
      prev_addr  = sif.bus_req_addr;
      prev_wdata = sif.bus_req_wdata;
      prev_we    = sif.bus_req_we;
    end
  end

  always @(negedge clock) begin
    if (!sif.bus_req_valid) begin
      sif.bus_req_ready = 1'b0;
      stall_cnt = 0;
    end else if (stall_cnt < stall_cfg) begin
      sif.bus_req_ready = 1'b0;
      stall_cnt++;
    end else begin
      sif.bus_req_ready = 1'b1;
    end
    if (spur) begin
      sif.bus_resp_valid = 1'b1;
      sif.bus_resp_rdata = 32'hDEAD_BEEF;
    end else if (resp_pending && pend_k != drop_beat) begin
      sif.bus_resp_valid = 1'b1;
      sif.bus_resp_rdata = rd_base + 32'(pend_k);
    end else begin
      sif.bus_resp_valid = 1'b0;
      sif.bus_resp_rdata = '0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base, input int nvalid);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 8; k++)
      if (k < nvalid) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic issue(input logic [31:0] addr, input logic we, input logic [255:0] data);
    sif.mem_req_addr  = addr;
    sif.mem_req_we    = we;
    sif.mem_req_data  = data;
    sif.mem_req_valid = 1'b1;
  endtask

  task automatic wait_resp(input int limit, output int cyc);
    cyc = 0;
    while (!sif.mem_resp_valid && cyc < limit) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic check_beats(input string tag, input int base, input logic [31:0] laddr,
                             input logic we, input logic [255:0] line);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_b%0d_addr", tag, k), 256'(b_addr[base+k]), 256'(laddr + 32'(4*k)));
      chk($sformatf("%s_b%0d_we", tag, k), 256'(b_we[base+k]), 256'(we));
      if (we) chk($sformatf("%s_b%0d_wdata", tag, k), 256'(b_wdata[base+k]), 256'(line[32*k +: 32]));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_resp_valid"}, 256'(sif.mem_resp_valid), '0);
    chk({tag, "_mem_resp_data"},  sif.mem_resp_data, '0);
    chk({tag, "_bus_req_valid"},  256'(sif.bus_req_valid), '0);
    chk({tag, "_bus_req_addr"},   256'(sif.bus_req_addr), '0);
    chk({tag, "_bus_req_we"},     256'(sif.bus_req_we), '0);
    chk({tag, "_bus_req_wdata"},  256'(sif.bus_req_wdata), '0);
    chk({tag, "_busy"},           256'(sif.busy), '0);
    chk({tag, "_timeout_err"},    256'(sif.timeout_err), '0);
  endtask

  initial begin
    int lat, base, base2, p0, s0, u0, d0, cyc;
    logic [255:0] wline;

    sif.mem_req_valid = 1'b0;
    sif.mem_req_addr  = '0;
    sif.mem_req_we    = 1'b0;
    sif.mem_req_data  = '0;

    step(2);
    chk_all_zero("rst");
    #3 reset = 1'b1;
    step(1);
    chk("idle_busy", 256'(sif.busy), '0);

    // Read line 0x1040, zero-wait bus: request cycle counts as cycle 1, pulse on cycle 18
    base = nbeats; p0 = pulses;
    issue(32'h0000_1040, 1'b0, '0);
    wait_resp(100, lat);
    sif.mem_req_valid = 1'b0;
    chk("rd_done", 256'(sif.mem_resp_valid), 256'(1));
    chk("rd_lat", 256'(lat), 256'(17));
    chk("rd_data", sif.mem_resp_data, mk_line(32'h100, 8));
    chk("rd_busy_in_done", 256'(sif.busy), 256'(1));
    step(1);
    chk("rd_pulse_len", 256'(sif.mem_resp_valid), '0);
    chk("rd_busy_after", 256'(sif.busy), '0);
    chk("rd_nbeats", 256'(nbeats - base), 256'(8));
    chk("rd_pulses", 256'(pulses - p0), 256'(1));
    check_beats("rd", base, 32'h0000_1040, 1'b0, '0);

    // Write line with 3 stall cycles per beat; request inputs scrambled while busy
    for (int k = 0; k < 8; k++) wline[32*k +: 32] = 32'hA0 + 32'(k);
    stall_cfg = 3;
    base = nbeats; p0 = pulses; s0 = stall_seen; u0 = unstable; d0 = drops;
    issue(32'h2000_0000, 1'b1, wline);
    step(2);
    sif.mem_req_addr = 32'hFFFF_FFE0;
    sif.mem_req_data = '1;
    sif.mem_req_we   = 1'b0;
    wait_resp(400, lat);
    sif.mem_req_valid = 1'b0;
    chk("wr_done", 256'(sif.mem_resp_valid), 256'(1));
    chk("wr_data_held", sif.mem_resp_data, mk_line(32'h100, 8));
    step(1);
    chk("wr_nbeats", 256'(nbeats - base), 256'(8));
    chk("wr_stalls", 256'(stall_seen - s0), 256'(24));
    chk("wr_stable", 256'(unstable - u0), '0);
    chk("wr_no_drop", 256'(drops - d0), '0);
    chk("wr_pulses", 256'(pulses - p0), 256'(1));
    check_beats("wr", base, 32'h2000_0000, 1'b1, wline);
    stall_cfg = 0;

    // Spurious response while idle
    p0 = pulses;
    spur = 1'b1;
    step(3);
    spur = 1'b0;
    chk("sp_idle_busy", 256'(sif.busy), '0);
    chk("sp_idle_valid", 256'(sif.bus_req_valid), '0);
    chk("sp_idle_data", sif.mem_resp_data, mk_line(32'h100, 8));
    step(1);
    chk("sp_idle_pulses", 256'(pulses - p0), '0);

    // Spurious response while a beat waits for ready
    stall_cfg = 6; rd_base = 32'h500;
    base = nbeats;
    issue(32'h0000_2080, 1'b0, '0);
    step(1);
    spur = 1'b1;
    step(3);
    spur = 1'b0;
    chk("sp_req_valid", 256'(sif.bus_req_valid), 256'(1));
    chk("sp_req_addr", 256'(sif.bus_req_addr), 256'(32'h0000_2080));
    chk("sp_req_nohs", 256'(nbeats - base), '0);
    wait_resp(300, lat);
    sif.mem_req_valid = 1'b0;
    chk("sp_done", 256'(sif.mem_resp_valid), 256'(1));
    chk("sp_data", sif.mem_resp_data, mk_line(32'h500, 8));
    step(1);
    stall_cfg = 0;

    // Back-to-back lines: request held through DONE
    rd_base = 32'h600;
    issue(32'h3000_0000, 1'b0, '0);
    wait_resp(100, lat);
    chk("b2b1_done", 256'(sif.mem_resp_valid), 256'(1));
    chk("b2b1_data", sif.mem_resp_data, mk_line(32'h600, 8));
    rd_base = 32'h700;
    sif.mem_req_addr = 32'h4000_0000;
    base2 = nbeats;
    step(1);
    chk("b2b_idle_busy", 256'(sif.busy), '0);
    chk("b2b_idle_pulse", 256'(sif.mem_resp_valid), '0);
    step(1);
    chk("b2b_start_valid", 256'(sif.bus_req_valid), 256'(1));
    chk("b2b_start_addr", 256'(sif.bus_req_addr), 256'(32'h4000_0000));
    chk("b2b_start_busy", 256'(sif.busy), 256'(1));
    sif.mem_req_valid = 1'b0;
    wait_resp(100, lat);
    chk("b2b2_done", 256'(sif.mem_resp_valid), 256'(1));
    chk("b2b2_lat", 256'(lat), 256'(16));
    chk("b2b2_data", sif.mem_resp_data, mk_line(32'h700, 8));
    check_beats("b2b2", base2, 32'h4000_0000, 1'b0, '0);
    step(1);

    // No response on beat 2
    rd_base = 32'h800; drop_beat = 2;
    base = nbeats; p0 = pulses;
    issue(32'h5000_0000, 1'b0, '0);
`ifdef MEM_SEQ_TIMEOUT_EN
    wait_resp(200, lat);
    sif.mem_req_valid = 1'b0;
    chk("tmo_done", 256'(sif.mem_resp_valid), 256'(1));
    chk("tmo_err", 256'(sif.timeout_err), 256'(1));
    chk("tmo_data", sif.mem_resp_data, mk_line(32'h800, 2));
    step(3);
    chk("tmo_sticky", 256'(sif.timeout_err), 256'(1));
    chk("tmo_idle", 256'(sif.busy), '0);
    chk("tmo_pulses", 256'(pulses - p0), 256'(1));
`else
    step(60);
    sif.mem_req_valid = 1'b0;
    chk("hang_busy", 256'(sif.busy), 256'(1));
    chk("hang_pulses", 256'(pulses - p0), '0);
    chk("hang_err", 256'(sif.timeout_err), '0);
    chk("hang_nbeats", 256'(nbeats - base), 256'(3));
`endif
    #2 reset = 1'b0;
    step(2);
    drop_beat = -1;
    chk("tmo_rst_err", 256'(sif.timeout_err), '0);
    chk("tmo_rst_busy", 256'(sif.busy), '0);
    #3 reset = 1'b1;
    step(1);

    // Asynchronous reset during beat 4 of a read
    rd_base = 32'h900;
    base = nbeats; p0 = pulses;
    issue(32'h6000_0040, 1'b0, '0);
    cyc = 0;
    while ((nbeats - base) < 5 && cyc < 100) begin
      step(1);
      cyc++;
    end
    chk("mid_beat4_reached", 256'((nbeats - base) >= 5), 256'(1));
    #2 reset = 1'b0;
    sif.mem_req_valid = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    step(2);
    #3 reset = 1'b1;
    step(1);
    chk("mid_no_pulse", 256'(pulses - p0), '0);
    chk("mid_idle", 256'(sif.busy), '0);

    rd_base = 32'hA00;
    base = nbeats;
    issue(32'h7000_0000, 1'b0, '0);
    wait_resp(100, lat);
    sif.mem_req_valid = 1'b0;
    chk("post_done", 256'(sif.mem_resp_valid), 256'(1));
    chk("post_lat", 256'(lat), 256'(17));
    chk("post_data", sif.mem_resp_data, mk_line(32'hA00, 8));
    step(1);
    chk("post_nbeats", 256'(nbeats - base), 256'(8));
    check_beats("post", base, 32'h7000_0000, 1'b0, '0);
    chk("no_valid_drop", 256'(drops), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_line_sequencer.md
MEM_LINE_SEQUENCER -- requirements
Module: mem_line_sequencer

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1024, max cycles waiting for one beat response (used only with MEM_SEQ_TIMEOUT_EN).
REQ-002 SHALL have ports (name direction width meaning):
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_req_valid  input  1  line request from cached CPU, held until mem_resp_valid.
- mem_req_addr  input  32  line address; bits [4:0] ignored.
- mem_req_we  input  1  1 = line write, 0 = line read.
- mem_req_data  input  256  write line data.
- mem_resp_valid  output  1  one-cycle completion pulse, read or write.
- mem_resp_data  output  256  assembled read line.
- bus_req_valid  output  1  word-bus beat request.
- bus_req_ready  input  1  bus accepts beat when valid&ready.
- bus_req_addr  output  32  beat word address.
- bus_req_we  output  1  beat write enable.
- bus_req_wdata  output  32  beat write data.
- bus_resp_valid  input  1  beat response/ack.
- bus_resp_rdata  input  32  beat read data.
- busy  output  1  high whenever state != IDLE.
- timeout_err  output  1  sticky timeout flag.

Function
REQ-003 SHALL serialize each 256-bit line into 8 32-bit beats, beat k = bits [32k+31:32k], issued k = 0..7 in order.
REQ-004 SHALL drive bus_req_addr = {line_addr[31:5], k[2:0], 2'b00}.
REQ-005 SHALL implement states IDLE, REQ, RESP, DONE.
REQ-006 IDLE: on mem_req_valid=1, SHALL latch addr, we and data, set k=0, and go to REQ next cycle.
REQ-007 REQ: SHALL hold bus_req_valid=1 with stable addr/we/wdata until bus_req_ready=1, then go to RESP.
REQ-008 RESP: on bus_resp_valid=1, a read SHALL store bus_resp_rdata into line word k.
- k<7: SHALL increment k and return to REQ.
- k=7: SHALL go to DONE.
REQ-009 DONE: SHALL assert mem_resp_valid for exactly one cycle, then return to IDLE.
REQ-010 Read completion SHALL present the full assembled line on mem_resp_data in DONE.
REQ-011 Write completion SHALL leave mem_resp_data unchanged.
REQ-012 Minimum line latency SHALL be 18 cycles: request seen in IDLE to mem_resp_valid, with ready and response each returned in the same cycle they are first possible.
REQ-013 Only one beat SHALL be outstanding; bus_resp_valid outside RESP SHALL be ignored.
REQ-014 bus_req_valid SHALL be 0 outside REQ and SHALL NOT drop in REQ before the handshake.
REQ-015 mem_req_* changes while busy=1 SHALL be ignored (latched copy used).
REQ-016 The requester deasserts mem_req_valid the cycle after mem_resp_valid. IDLE SHALL accept a new request on the first cycle after DONE if mem_req_valid=1.
REQ-017 mem_resp_data SHALL hold its value between completions.

Reset
REQ-018 reset=0 SHALL asynchronously force state IDLE and k=0.
REQ-019 reset=0 SHALL force mem_resp_valid, bus_req_valid, busy and timeout_err to 0.
REQ-020 reset=0 SHALL force mem_resp_data, bus_req_addr, bus_req_we and bus_req_wdata to 0.
REQ-021 Reset mid-line SHALL abandon the transfer with no mem_resp_valid. Release SHALL be synchronized to clock.

Configuration
REQ-022 With MEM_SEQ_TIMEOUT_EN defined, a counter SHALL reset on each entry to RESP and increment each cycle in RESP.
- Reaching TIMEOUT_CYCLES without bus_resp_valid SHALL set timeout_err=1, sticky until reset.
- It SHALL then go to DONE and pulse mem_resp_valid; unreceived read words SHALL read as 0.
REQ-023 Without MEM_SEQ_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied 0, and RESP SHALL wait indefinitely.

Verification
REQ-024 Read line 0x0000_1040, ready=1, response data 0x100+k in the same cycle -> 8 beats at addresses 0x1040..0x105C, mem_resp_valid on cycle 18, mem_resp_data word k = 0x100+k.
REQ-025 Write line 0x2000_0000, data word k = 0xA0+k, ready stalled 3 cycles per beat -> bus_req_wdata/addr stable during each stall, beats in order, one mem_resp_valid pulse, mem_resp_data unchanged.
REQ-026 Spurious bus_resp_valid in IDLE and in REQ -> no state change, no data captured.
REQ-027 reset=0 during beat 4 of a read -> all outputs 0 immediately. Next request runs cleanly from beat 0.
REQ-028 MEM_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response on beat 2 -> timeout_err=1, mem_resp_valid pulses, words 2..7 = 0. Without the macro, busy stays 1 with no pulse.
REQ-029 Back-to-back requests (mem_req_valid reasserted the cycle after DONE) -> second line starts with no idle gap beyond one IDLE cycle.
